// File: rtl/ao_timer_array.sv
// ao_timer_array: always-on timer/watchdog array.
//
// NCH independent down-counters behind one APB slave. A shared prescaler,
// advanced by the external tick_en strobe, produces the count tick (ctick).
// Each channel runs as one-shot, periodic or two-stage watchdog.
//
// Ports:
//   pclk, presetn          block clock, asynchronous active-low reset
//   psel/penable/pwrite    APB control
//   paddr, pwdata          APB byte address ([1:0] ignored), write data
//   prdata, pready,        APB read data (combinational on paddr), always-ready,
//   pslverr                error on unmapped access
//   tick_en                one-cycle reference tick
//   irq[NCH]               per-channel level interrupt (pend & ie, registered)
//   wdtrst                 sticky watchdog reset request
//
// Build option: define AO_TIMER_WDT_LOCK_EN to add the LOCK register at 0x104
// that protects watchdog configuration. Without it 0x104 is unmapped.
module ao_timer_array #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 32,
    parameter int unsigned PSW = 16,
    parameter int unsigned PAW = 12
) (
    input  logic           pclk,
    input  logic           presetn,
    input  logic           psel,
    input  logic           penable,
    input  logic           pwrite,
    input  logic [PAW-1:0] paddr,
    input  logic [31:0]    pwdata,
    output logic [31:0]    prdata,
    output logic           pready,
    output logic           pslverr,
    input  logic           tick_en,
    output logic [NCH-1:0] irq,
    output logic           wdtrst
);

    localparam logic [1:0]  ModePeriodic = 2'd1;
    localparam logic [1:0]  ModeWdt      = 2'd2;
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PGW = PAW - 8;

    logic [NCH-1:0]         en_q, en_d, ie_q, ie_d, stage_q, stage_d;
    logic [NCH-1:0]         pend_q, pend_d, irq_q, irq_d;
    logic [NCH-1:0][1:0]    mode_q, mode_d;
    logic [NCH-1:0][CW-1:0] load_q, load_d, value_q, value_d;
    logic [PSW-1:0]         psc_q, psc_d, presc_q, presc_d;
    logic                   wdtrst_q, wdtrst_d;
    logic                   locked;

    // Address decode: channels at page 0 (ch*0x10), globals at page 1 (0x100..0x10C)
    logic [PGW-1:0] page;
    logic [3:0]     slot;
    logic [CHW-1:0] ch_idx;
    logic [1:0]     reg_off;
    logic           ch_space, glb_mapped, mapped, access, wr_en, ctick;
    logic           unused_paddr;

    assign page         = paddr[PAW-1:8];
    assign slot         = paddr[7:4];
    assign ch_idx       = slot[CHW-1:0];
    assign reg_off      = paddr[3:2];
    assign unused_paddr = ^paddr[1:0];
    assign ch_space     = (page == '0) && (32'(slot) < NCH);

    always_comb begin
        glb_mapped = 1'b0;
        if (page == PGW'(1) && slot == 4'd0) begin
            case (reg_off)
                2'd0, 2'd2: glb_mapped = 1'b1;
`ifdef AO_TIMER_WDT_LOCK_EN
                2'd1:       glb_mapped = 1'b1;
`endif
                default:    glb_mapped = 1'b0;
            endcase
        end
    end

    assign mapped  = ch_space | glb_mapped;
    assign access  = psel & penable;
    assign wr_en   = access & pwrite & mapped;
    assign pslverr = access & ~mapped;
    assign pready  = 1'b1;
    assign irq     = irq_q;
    assign wdtrst  = wdtrst_q;

`ifdef AO_TIMER_WDT_LOCK_EN
    localparam logic [31:0] UnlockKey = 32'h1ACCE551;
    logic lock_q, lock_d;

    assign locked = lock_q;
    // Any value other than the key re-locks.
    assign lock_d = (wr_en && glb_mapped && reg_off == 2'd1) ? (pwdata != UnlockKey) : lock_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            lock_q <= 1'b1;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign locked = 1'b0;
`endif

    // Read mux
    always_comb begin
        prdata = '0;
        if (ch_space) begin
            case (reg_off)
                2'd0:    prdata[3:0]    = {ie_q[ch_idx], mode_q[ch_idx], en_q[ch_idx]};
                2'd1:    prdata[CW-1:0] = load_q[ch_idx];
                2'd2:    prdata[CW-1:0] = value_q[ch_idx];
                default: prdata[1:0]    = {stage_q[ch_idx], pend_q[ch_idx]};
            endcase
        end else if (glb_mapped) begin
            case (reg_off)
                2'd0:    prdata[NCH-1:0] = pend_q;
`ifdef AO_TIMER_WDT_LOCK_EN
                2'd1:    prdata[0]       = locked;
`endif
                default: prdata[PSW-1:0] = presc_q;
            endcase
        end
    end

    always_comb begin : next_state
        logic ch_wr, ctrl_wr, load_wr, stat_wr, run, any_wdt;
        ch_wr    = 1'b0;
        ctrl_wr  = 1'b0;
        load_wr  = 1'b0;
        stat_wr  = 1'b0;
        run      = 1'b0;
        any_wdt  = 1'b0;
        en_d     = en_q;
        ie_d     = ie_q;
        mode_d   = mode_q;
        stage_d  = stage_q;
        pend_d   = pend_q;
        load_d   = load_q;
        value_d  = value_q;
        presc_d  = presc_q;
        wdtrst_d = wdtrst_q;
        irq_d    = pend_q & ie_q;

        psc_d = psc_q;
        ctick = 1'b0;
        if (tick_en) begin
            if (psc_q == presc_q) begin
                psc_d = '0;
                ctick = 1'b1;
            end else begin
                psc_d = psc_q + PSW'(1);
            end
        end

        for (int i = 0; i < NCH; i++) begin
            if (mode_q[i] == ModeWdt) any_wdt = 1'b1;
        end
        if (wr_en && glb_mapped && reg_off == 2'd2 && !(locked && any_wdt)) begin
            presc_d = pwdata[PSW-1:0];
        end

        for (int i = 0; i < NCH; i++) begin
            ch_wr   = wr_en && ch_space && (int'(ch_idx) == i);
            ctrl_wr = ch_wr && reg_off == 2'd0 &&
                      !(locked && (mode_q[i] == ModeWdt || pwdata[2:1] == ModeWdt));
            load_wr = ch_wr && reg_off == 2'd1;
            stat_wr = ch_wr && reg_off == 2'd3;
            // A LOAD write or an en-clearing CTRL write takes precedence over ctick.
            run     = en_q[i] && !(ctrl_wr && !pwdata[0]) && !load_wr;

            if (stat_wr && pwdata[0]) pend_d[i] = 1'b0;

            if (ctrl_wr) begin
                en_d[i]   = pwdata[0];
                mode_d[i] = pwdata[2:1];
                ie_d[i]   = pwdata[3];
                if (pwdata[0] && !en_q[i]) begin
                    value_d[i] = load_q[i];
                    stage_d[i] = 1'b0;
                end
            end

            if (load_wr) begin
                load_d[i]  = pwdata[CW-1:0];
                value_d[i] = pwdata[CW-1:0];
                stage_d[i] = 1'b0;
            end

            if (ctick && run) begin
                if (value_q[i] != '0) begin
                    value_d[i] = value_q[i] - CW'(1);
                end else begin
                    case (mode_q[i])
                        ModePeriodic: begin
                            pend_d[i]  = 1'b1;
                            value_d[i] = load_q[i];
                        end
                        ModeWdt: begin
                            value_d[i] = load_q[i];
                            if (stage_q[i]) begin
                                wdtrst_d = 1'b1;
                            end else begin
                                pend_d[i]  = 1'b1;
                                stage_d[i] = 1'b1;
                            end
                        end
                        // One-shot and the reserved encoding
                        default: begin
                            pend_d[i] = 1'b1;
                            en_d[i]   = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            en_q     <= '0;
            ie_q     <= '0;
            mode_q   <= '0;
            stage_q  <= '0;
            pend_q   <= '0;
            irq_q    <= '0;
            load_q   <= '0;
            value_q  <= '0;
            psc_q    <= '0;
            presc_q  <= '0;
            wdtrst_q <= 1'b0;
        end else begin
            en_q     <= en_d;
            ie_q     <= ie_d;
            mode_q   <= mode_d;
            stage_q  <= stage_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
            load_q   <= load_d;
            value_q  <= value_d;
            psc_q    <= psc_d;
            presc_q  <= presc_d;
            wdtrst_q <= wdtrst_d;
        end
    end

endmodule

// File: tb/tb_ao_timer_array.sv
`timescale 1ns/1ps
module tb_ao_timer_array;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 32;
    localparam int unsigned PSW = 16;
    localparam int unsigned PAW = 12;

    localparam logic [PAW-1:0] AddrIrqstat = 12'h100;
    localparam logic [PAW-1:0] AddrLock    = 12'h104;
    localparam logic [PAW-1:0] AddrPresc   = 12'h108;

    logic           pclk = 1'b0;
    logic           presetn;
    logic           psel, penable, pwrite, tick_en;
    logic [PAW-1:0] paddr;
    logic [31:0]    pwdata, prdata;
    logic           pready, pslverr, wdtrst;
    logic [NCH-1:0] irq;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    ao_timer_array #(.NCH(NCH), .CW(CW), .PSW(PSW), .PAW(PAW)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tick_en (tick_en),
        .irq     (irq),
        .wdtrst  (wdtrst)
    );

    function automatic logic [PAW-1:0] ra(input int ch, input int off);
        return PAW'(ch * 16 + off);
    endfunction

    // One APB transfer; optionally raises tick_en in the access cycle.
    task automatic apb(input logic wr, input logic [PAW-1:0] a, input logic [31:0] wd,
                       input logic with_tick, output logic [31:0] rd_data, output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1; tick_en = with_tick;
        #1;
        rd_data = prdata;
        err     = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tick_en = 1'b0;
    endtask

    task automatic wr(input logic [PAW-1:0] a, input logic [31:0] wd);
        logic [31:0] d; logic e;
        apb(1'b1, a, wd, 1'b0, d, e);
    endtask

    task automatic wr_tick(input logic [PAW-1:0] a, input logic [31:0] wd);
        logic [31:0] d; logic e;
        apb(1'b1, a, wd, 1'b1, d, e);
    endtask

    task automatic rd(input logic [PAW-1:0] a, output logic [31:0] d);
        logic e;
        apb(1'b0, a, 32'h0, 1'b0, d, e);
    endtask

    task automatic tick_gap(input int gap);
        repeat (gap) @(posedge pclk);
        @(posedge pclk); #1;
        tick_en = 1'b1;
        @(posedge pclk); #1;
        tick_en = 1'b0;
    endtask

    task automatic do_reset();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tick_en = 1'b0;
        paddr = '0; pwdata = '0;
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        #2 presetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [PAW-1:0] addrs [6];
        do_reset();
        addrs = '{ra(0, 0), ra(0, 4), ra(0, 8), ra(3, 12), AddrIrqstat, AddrPresc};
        checks++; if (irq !== '0) begin errors++; $display("FAIL reset_irq: got %0h want 0", irq); end
        checks++; if (wdtrst !== 1'b0) begin errors++; $display("FAIL reset_wdtrst: got %0b want 0", wdtrst); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %0b want 0", pslverr); end
        foreach (addrs[k]) begin
            rd(addrs[k], d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL reset_reg %0h: got %0h want 0", addrs[k], d); end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        int ld;
        logic exp_pend;
        int exp_val;
        ld = 3;
        do_reset();
        wr(AddrPresc, 0);
        wr(ra(0, 4), 32'(ld));
        wr(ra(0, 0), 32'hB);
        for (int t = 1; t <= 9; t++) begin
            tick_gap(8);
            exp_pend = (t % (ld + 1) == 0);
            exp_val  = ld - (t % (ld + 1));
            if (t == ld + 1) begin
                checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL periodic_irq_lag: got %0b want 0", irq[0]); end
                @(posedge pclk); #1;
                checks++; if (irq[0] !== 1'b1) begin errors++; $display("FAIL periodic_irq: got %0b want 1", irq[0]); end
            end
            rd(ra(0, 12), d);
            checks++; if (d[0] !== exp_pend) begin errors++; $display("FAIL periodic_pend t=%0d: got %0b want %0b", t, d[0], exp_pend); end
            rd(ra(0, 8), d);
            checks++; if (d !== 32'(exp_val)) begin errors++; $display("FAIL periodic_value t=%0d: got %0h want %0h", t, d, exp_val); end
            if (exp_pend) wr(ra(0, 12), 32'h1);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        do_reset();
        wr(AddrPresc, 2);
        wr(ra(1, 4), 0);
        wr(ra(1, 0), 32'h1);
        for (int t = 1; t <= 6; t++) begin
            tick_gap(2);
            rd(ra(1, 12), d);
            checks++; if (d[0] !== (t == 3)) begin errors++; $display("FAIL oneshot_pend t=%0d: got %0b want %0b", t, d[0], (t == 3)); end
            if (d[0]) wr(ra(1, 12), 32'h1);
            rd(ra(1, 0), d);
            checks++; if (d[0] !== (t < 3)) begin errors++; $display("FAIL oneshot_en t=%0d: got %0b want %0b", t, d[0], (t < 3)); end
            rd(ra(1, 8), d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_value t=%0d: got %0h want 0", t, d); end
        end
        checks++; if (irq[1] !== 1'b0) begin errors++; $display("FAIL oneshot_irq_masked: got %0b want 0", irq[1]); end
    endtask

    task automatic test_watchdog();
        logic [31:0] d;
        int k;
        do_reset();
        wr(ra(2, 4), 5);
        wr(ra(2, 0), 32'hD);
        for (int t = 1; t <= 12; t++) begin
            tick_gap(1);
            rd(ra(2, 12), d);
            checks++;
            if (d[1:0] !== {t >= 6, t >= 6}) begin
                errors++; $display("FAIL wdt_stat t=%0d: got %0h want %0h", t, d[1:0], {t >= 6, t >= 6});
            end
            checks++; if (wdtrst !== (t >= 12)) begin errors++; $display("FAIL wdt_rst t=%0d: got %0b want %0b", t, wdtrst, (t >= 12)); end
        end
        // Reset mid-count must clear outputs without waiting for a clock edge.
        paddr = ra(2, 8);
        @(posedge pclk); #3;
        presetn = 1'b0;
        #1;
        checks++; if (wdtrst !== 1'b0) begin errors++; $display("FAIL async_rst_wdtrst: got %0b want 0", wdtrst); end
        checks++; if (irq !== '0) begin errors++; $display("FAIL async_rst_irq: got %0h want 0", irq); end
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL async_rst_prdata: got %0h want 0", prdata); end
        repeat (2) @(posedge pclk);
        #2 presetn = 1'b1;

        // Kicked watchdog: ticks counted since the last kick
        wr(ra(2, 4), 5);
        wr(ra(2, 0), 32'hD);
        for (int t = 1; t <= 16; t++) begin
            tick_gap(1);
            if (t == 9) wr(ra(2, 4), 5);
            k = (t < 9) ? t : t - 9;
            rd(ra(2, 12), d);
            checks++;
            if (d[1:0] !== {k >= 6, t >= 6}) begin
                errors++; $display("FAIL kick_stat t=%0d: got %0h want %0h", t, d[1:0], {k >= 6, t >= 6});
            end
            checks++; if (wdtrst !== 1'b0) begin errors++; $display("FAIL kick_rst t=%0d: got %0b want 0", t, wdtrst); end
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        do_reset();
        wr(ra(3, 4), 1);
        wr(ra(3, 0), 32'h3);
        repeat (3) tick_gap(0);
        wr_tick(ra(3, 12), 32'h1);
        rd(ra(3, 12), d);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL w1c_vs_set: got %0b want 1", d[0]); end
        wr(ra(3, 12), 32'h1);
        rd(ra(3, 12), d);
        checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %0b want 0", d[0]); end
        wr_tick(ra(3, 4), 7);
        rd(ra(3, 8), d);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL load_vs_ctick: got %0h want 7", d); end
        wr(ra(3, 4), 0);
        wr_tick(ra(3, 0), 32'h2);
        rd(ra(3, 12), d);
        checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL enclr_vs_expiry_pend: got %0b want 0", d[0]); end
        rd(ra(3, 0), d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL enclr_ctrl: got %0h want 2", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic e;
        do_reset();
        wr(AddrPresc, 5);
        wr(ra(0, 0), 32'hB);
        apb(1'b0, 12'h0FC, 32'h0, 1'b0, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_rd_0fc_pslverr: got %0b want 1", e); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_rd_0fc_prdata: got %0h want 0", d); end
        apb(1'b1, 12'h200, 32'hFFFF_FFFF, 1'b0, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_200_pslverr: got %0b want 1", e); end
        apb(1'b0, 12'h040, 32'h0, 1'b0, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_rd_ch4_pslverr: got %0b want 1", e); end
        apb(1'b0, ra(0, 4), 32'h0, 1'b0, d, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ok_rd_load_pslverr: got %0b want 0", e); end
        rd(AddrPresc, d);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL err_presc_kept: got %0h want 5", d); end
        rd(ra(0, 0), d);
        checks++; if (d !== 32'hB) begin errors++; $display("FAIL err_ctrl_kept: got %0h want b", d); end
`ifndef AO_TIMER_WDT_LOCK_EN
        apb(1'b0, AddrLock, 32'h0, 1'b0, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL nolock_pslverr: got %0b want 1", e); end
`endif
    endtask

`ifdef AO_TIMER_WDT_LOCK_EN
    task automatic test_lock();
        logic [31:0] d;
        do_reset();
        rd(AddrLock, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL lock_reset: got %0h want 1", d); end
        wr(ra(2, 0), 32'h5);
        rd(ra(2, 0), d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL lock_mode_to_wdt: got %0h want 0", d); end
        wr(AddrLock, 32'h1ACCE551);
        rd(AddrLock, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL lock_unlocked: got %0h want 0", d); end
        wr(ra(2, 4), 9);
        wr(ra(2, 0), 32'h5);
        wr(AddrLock, 32'h0);
        wr(ra(2, 0), 32'h4);
        rd(ra(2, 0), d);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL lock_ctrl_ignored: got %0h want 5", d); end
        tick_gap(0);
        rd(ra(2, 8), d);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL lock_still_counting: got %0h want 8", d); end
        wr(ra(2, 4), 9);
        rd(ra(2, 8), d);
        checks++; if (d !== 32'h9) begin errors++; $display("FAIL lock_kick: got %0h want 9", d); end
        wr(AddrPresc, 3);
        rd(AddrPresc, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL lock_presc: got %0h want 0", d); end
        wr(AddrLock, 32'h1ACCE551);
        wr(ra(2, 0), 32'h4);
        tick_gap(0);
        rd(ra(2, 8), d);
        checks++; if (d !== 32'h9) begin errors++; $display("FAIL unlock_stop: got %0h want 9", d); end
    endtask
`endif

    // Random single-channel runs against a tick-count model.
    task automatic test_random();
        logic [31:0] d;
        logic [NCH-1:0] exp_vec;
        int ch, ld, ps, md, nt, c, exp_val;
        logic exp_pend;
        for (int trial = 0; trial < 6; trial++) begin
            do_reset();
            ch = $urandom_range(0, NCH - 1);
            ld = $urandom_range(0, 6);
            ps = $urandom_range(0, 3);
            md = $urandom_range(0, 1);
            nt = $urandom_range(6, 20);
            wr(AddrPresc, 32'(ps));
            wr(ra(ch, 4), 32'(ld));
            wr(ra(ch, 0), 32'(8 + md * 2 + 1));
            for (int t = 1; t <= nt; t++) begin
                tick_gap($urandom_range(0, 3));
                c        = t / (ps + 1);
                exp_pend = (c > ld);
                if (md == 1) exp_val = ld - (c % (ld + 1));
                else         exp_val = (c > ld) ? 0 : ld - c;
                exp_vec     = '0;
                exp_vec[ch] = exp_pend;
                rd(ra(ch, 8), d);
                checks++;
                if (d !== 32'(exp_val)) begin
                    errors++; $display("FAIL rand_value tr=%0d t=%0d: got %0h want %0h", trial, t, d, exp_val);
                end
                rd(AddrIrqstat, d);
                checks++;
                if (d !== 32'(exp_vec)) begin
                    errors++; $display("FAIL rand_irqstat tr=%0d t=%0d: got %0h want %0h", trial, t, d, exp_vec);
                end
                checks++;
                if (irq !== exp_vec) begin
                    errors++; $display("FAIL rand_irq tr=%0d t=%0d: got %0h want %0h", trial, t, irq, exp_vec);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_watchdog();
        test_simultaneous();
        test_errors();
`ifdef AO_TIMER_WDT_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
